// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue/writeback controller in front of a clocked 64-bit ALU.
// Takes register-addressed instructions over valid/ready, drives the ALU
// operands for one cycle, then writes the registered result back to the
// register file and publishes the raw ALU flags. One instruction per 3 cycles.
module alu_issue_ctrl #(
    parameter int W    = 64,
    parameter int NREG = 8,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_op,
    input  logic [AW-1:0] in_rd,
    input  logic [AW-1:0] in_rs1,
    input  logic [AW-1:0] in_rs2,

    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    output logic [3:0]    alu_op,
    input  logic [W-1:0]  alu_y,
    input  logic          alu_zf,
    input  logic          alu_sf,
    input  logic          alu_cf,
    input  logic          alu_of,

    output logic          wb_valid,
    output logic [AW-1:0] wb_rd,
    output logic [W-1:0]  wb_data,
    output logic [3:0]    flags,

    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [W-1:0]  ld_data,

    input  logic [AW-1:0] dbg_addr,
    output logic [W-1:0]  dbg_data
);

    // Opcode presented to the ALU whenever no instruction is being issued.
    localparam logic [3:0] OP_PASS = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE
    } state_t;

    state_t state, state_nxt;

    logic [W-1:0]  regfile [NREG];
    logic [3:0]    op_q;
    logic [AW-1:0] rd_q, rs1_q, rs2_q;
    logic          accept;
    logic          capture;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of every other flop.
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic and ALU-facing outputs.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a signal unassigned, which would infer a latch.
        state_nxt = state;
        in_ready  = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        alu_op    = OP_PASS;
        case (state)
            S_IDLE: begin
                in_ready = !rst;
                accept   = in_valid && !rst;
                if (accept) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                alu_a     = regfile[rs1_q];
                alu_b     = regfile[rs2_q];
                alu_op    = op_q;
                state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                capture   = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Latched instruction fields; only consumed after an accept, so no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q  <= in_op;
            rd_q  <= in_rd;
            rs1_q <= in_rs1;
            rs2_q <= in_rs2;
        end
    end

    // Register file: direct load port plus writeback; writeback wins on a
    // same-address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the register file is architecturally visible and must read
            // zero after reset, so it is cleared entry by entry here.
            for (int i = 0; i < NREG; i++) regfile[i] <= '0;
        end else begin
            if (ld_en && !(capture && (ld_addr == rd_q))) regfile[ld_addr] <= ld_data;
            if (capture) regfile[rd_q] <= alu_y;
        end
    end

    // Writeback report and flag capture at the CAPTURE edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
            flags    <= '0;
        end else begin
            wb_valid <= capture;
            if (capture) begin
                wb_rd   <= rd_q;
                wb_data <= alu_y;
                flags   <= {alu_zf, alu_sf, alu_cf, alu_of};
            end
        end
    end

    assign dbg_data = regfile[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl. A small behavioural clocked ALU stands in
// for the real one (ADD, SUB, XOR; anything else passes operand A through).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_alu_issue_ctrl;

    localparam int W  = 64;
    localparam int AW = 3;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_op;
    logic [AW-1:0] in_rd, in_rs1, in_rs2;
    logic [W-1:0]  alu_a, alu_b;
    logic [3:0]    alu_op;
    logic [W-1:0]  alu_y;
    logic          alu_zf, alu_sf, alu_cf, alu_of;
    logic          wb_valid;
    logic [AW-1:0] wb_rd;
    logic [W-1:0]  wb_data;
    logic [3:0]    flags;
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [W-1:0]  ld_data;
    logic [AW-1:0] dbg_addr;
    logic [W-1:0]  dbg_data;

    int checks   = 0;
    int failures = 0;
    int pulses;

    alu_issue_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_rd    (in_rd),
        .in_rs1   (in_rs1),
        .in_rs2   (in_rs2),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_op   (alu_op),
        .alu_y    (alu_y),
        .alu_zf   (alu_zf),
        .alu_sf   (alu_sf),
        .alu_cf   (alu_cf),
        .alu_of   (alu_of),
        .wb_valid (wb_valid),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .flags    (flags),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: returns {y, zf, sf, cf, of}.
    function automatic logic [W+3:0] alu_eval(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [3:0] op);
        logic [W:0]   sum;
        logic [W-1:0] y;
        logic         cf, of;
        cf = 1'b0;
        of = 1'b0;
        case (op)
            4'b0000: begin
                sum = {1'b0, a} + {1'b0, b};
                y   = sum[W-1:0];
                cf  = sum[W];
                of  = (a[W-1] == b[W-1]) && (y[W-1] != a[W-1]);
            end
            4'b0001: begin
                y  = a - b;
                cf = a < b;
                of = (a[W-1] != b[W-1]) && (y[W-1] != a[W-1]);
            end
            4'b0101: y = a ^ b;
            default: y = a;
        endcase
        return {y, (y == '0), y[W-1], cf, of};
    endfunction

    // Registered ALU result, one cycle after the operands are presented.
    always @(posedge clk) begin
        {alu_y, alu_zf, alu_sf, alu_cf, alu_of} <= alu_eval(alu_a, alu_b, alu_op);
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns on the next falling edge with the load done.
    task automatic load(input logic [AW-1:0] a, input logic [W-1:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    // Issues one instruction from IDLE and checks the full 3-cycle sequence.
    task automatic run_instr(input string tag, input logic [3:0] op, input logic [AW-1:0] rd,
                             input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                             input logic [W-1:0] exp_data, input logic [3:0] exp_flags);
        check({tag, " ready_idle"}, in_ready, 1);
        in_valid = 1'b1;
        in_op    = op;
        in_rd    = rd;
        in_rs1   = rs1;
        in_rs2   = rs2;
        @(negedge clk);
        // Scramble the instruction fields: the latched copies must be used.
        in_valid = 1'b0;
        in_op    = ~op;
        in_rd    = ~rd;
        in_rs1   = ~rs1;
        in_rs2   = ~rs2;
        check({tag, " ready_issue"}, in_ready, 0);
        check({tag, " alu_op_issue"}, alu_op, op);
        @(negedge clk);
        check({tag, " ready_capture"}, in_ready, 0);
        check({tag, " wb_valid_capture"}, wb_valid, 0);
        check({tag, " alu_op_capture"}, alu_op, 4'b1111);
        @(negedge clk);
        check({tag, " wb_valid"}, wb_valid, 1);
        check({tag, " wb_rd"}, wb_rd, rd);
        check({tag, " wb_data"}, wb_data, exp_data);
        check({tag, " flags"}, flags, exp_flags);
        dbg_addr = rd;
        #1;
        check({tag, " dbg_rd"}, dbg_data, exp_data);
        @(negedge clk);
        check({tag, " wb_valid_drop"}, wb_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_op    = '0;
        in_rd    = '0;
        in_rs1   = '0;
        in_rs2   = '0;
        ld_en    = 1'b0;
        ld_addr  = '0;
        ld_data  = '0;
        dbg_addr = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst in_ready", in_ready, 0);
        check("rst wb_valid", wb_valid, 0);
        check("rst flags", flags, 0);
        check("rst wb_rd", wb_rd, 0);
        check("rst wb_data", wb_data, 0);
        check("rst alu_op", alu_op, 4'b1111);
        check("rst dbg r0", dbg_data, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst in_ready", in_ready, 1);

        // ADD 5 + 3.
        load(3'd1, 64'd5);
        load(3'd2, 64'd3);
        run_instr("add", 4'b0000, 3'd3, 3'd1, 3'd2, 64'd8, 4'b0000);

        // SUB 3 - 5: negative with borrow.
        run_instr("sub", 4'b0001, 3'd4, 3'd2, 3'd1, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0110);

        // Signed overflow on ADD.
        load(3'd1, 64'h7FFF_FFFF_FFFF_FFFF);
        load(3'd2, 64'd1);
        run_instr("add_ovf", 4'b0000, 3'd5, 3'd1, 3'd2, 64'h8000_0000_0000_0000, 4'b0101);

        // XOR with itself: zero.
        run_instr("xor_zero", 4'b0101, 3'd6, 3'd1, 3'd1, 64'd0, 4'b1000);

        // Held in_valid: r7 = r7 + r2 three times, accepts 3 cycles apart.
        in_valid = 1'b1;
        in_op    = 4'b0000;
        in_rd    = 3'd7;
        in_rs1   = 3'd7;
        in_rs2   = 3'd2;
        pulses   = 0;
        for (int k = 0; k < 10; k++) begin
            if (k == 7) in_valid = 1'b0;
            check($sformatf("held ready k=%0d", k), in_ready, (k % 3 == 0) ? 1 : 0);
            check($sformatf("held wb_valid k=%0d", k), wb_valid,
                  (k >= 3 && k % 3 == 0) ? 1 : 0);
            if (wb_valid) pulses++;
            @(negedge clk);
        end
        check("held pulses", pulses, 3);
        dbg_addr = 3'd7;
        #1;
        check("held dbg r7", dbg_data, 64'd3);
        @(negedge clk);

        // Load during ISSUE to a source and to rd on the CAPTURE edge.
        in_valid = 1'b1;
        in_op    = 4'b0000;
        in_rd    = 3'd3;
        in_rs1   = 3'd3;
        in_rs2   = 3'd2;
        @(negedge clk);
        in_valid = 1'b0;
        ld_en    = 1'b1;
        ld_addr  = 3'd2;
        ld_data  = 64'h100;
        check("coll alu_b_issue", alu_b, 64'd1);
        @(negedge clk);
        ld_addr  = 3'd3;
        ld_data  = 64'hDEAD;
        @(negedge clk);
        ld_en    = 1'b0;
        check("coll wb_valid", wb_valid, 1);
        check("coll wb_data", wb_data, 64'd9);
        dbg_addr = 3'd3;
        #1;
        check("coll dbg r3", dbg_data, 64'd9);
        dbg_addr = 3'd2;
        #1;
        check("coll dbg r2", dbg_data, 64'h100);
        @(negedge clk);

        // Sets flags to a non-zero value ahead of the abort test.
        run_instr("xor_r3", 4'b0101, 3'd5, 3'd3, 3'd3, 64'd0, 4'b1000);

        // Reset during CAPTURE aborts the instruction.
        in_valid = 1'b1;
        in_op    = 4'b0001;
        in_rd    = 3'd4;
        in_rs1   = 3'd3;
        in_rs2   = 3'd2;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort wb_valid", wb_valid, 0);
        check("abort flags", flags, 0);
        check("abort wb_data", wb_data, 0);
        check("abort wb_rd", wb_rd, 0);
        check("abort in_ready", in_ready, 0);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = AW'(i);
            #0.1;
            check($sformatf("abort dbg r%0d", i), dbg_data, 0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("after_abort wb_valid", wb_valid, 0);
        check("after_abort in_ready", in_ready, 1);
        check("after_abort flags", flags, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
